// File: rtl/pipe_ctrl.sv
// Pipeline control unit: turns load-use stalls, EX redirects and the MEM handshake into
// per-stage enable/bubble/flush strobes and a PC redirect. Perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_stall,
  input  logic             i_ex_redirect,
  input  logic [31:0]      i_ex_redirect_pc,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_ex_mem_bubble,
  output logic             o_mem_wb_bubble,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_pc_load,
  output logic [31:0]      o_pc_next,
  output logic             o_mem_timeout,
  output logic [1:0]       o_ctrl_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events,
  output logic [CNT_W-1:0] o_mem_wait_cycles
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2,
    StError   = 2'd3
  } state_e;

  localparam logic [3:0]  FlushInit  = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);
  localparam state_e      RedirState = (FLUSH_CYCLES > 1) ? StFlush : StRun;

  state_e      r_state, w_state_d;
  logic [3:0]  r_flush_cnt, w_flush_cnt_d;
  logic [15:0] r_wait_cnt, w_wait_cnt_d;
  logic        r_mem_timeout, w_mem_timeout_d;
  logic        w_freeze;
  logic        w_apply;
  logic        w_stall_applied;

  always_comb begin
    w_state_d       = r_state;
    w_flush_cnt_d   = r_flush_cnt;
    w_wait_cnt_d    = r_wait_cnt;
    w_mem_timeout_d = r_mem_timeout;
    w_freeze        = 1'b0;
    w_apply         = 1'b0;
    w_stall_applied = 1'b0;

    unique case (r_state)
      StRun, StFlush: begin
        if (i_mem_req && !i_mem_ack) begin
          // Freeze wins; any pending flush count is dropped.
          w_freeze      = 1'b1;
          w_state_d     = StMemWait;
          w_wait_cnt_d  = 16'd1;
          w_flush_cnt_d = '0;
        end else begin
          w_apply = 1'b1;
          if (r_state == StFlush && r_flush_cnt > 4'd1) begin
            w_flush_cnt_d = r_flush_cnt - 4'd1;
          end else begin
            w_state_d     = StRun;
            w_flush_cnt_d = '0;
          end
        end
      end
      StMemWait: begin
        if (i_mem_ack) begin
          w_apply       = 1'b1;
          w_state_d     = StRun;
          w_flush_cnt_d = '0;
        end else begin
          w_freeze     = 1'b1;
          w_wait_cnt_d = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;
          if (r_wait_cnt == TimeoutVal) begin
            w_state_d       = StError;
            w_mem_timeout_d = 1'b1;
          end
        end
      end
      StError: begin
        w_state_d = StError;
      end
      default: begin
        w_state_d = StRun;
      end
    endcase

    o_if_id_en      = (r_state != StError);
    o_id_ex_en      = (r_state != StError);
    o_ex_mem_en     = (r_state != StError);
    o_mem_wb_en     = (r_state != StError);
    o_ex_mem_bubble = 1'b0;
    o_mem_wb_bubble = 1'b0;
    o_if_id_flush   = 1'b0;
    o_id_ex_flush   = 1'b0;
    o_pc_load       = 1'b0;
    o_pc_next       = '0;

    if (w_freeze) begin
      o_if_id_en      = 1'b0;
      o_id_ex_en      = 1'b0;
      o_ex_mem_en     = 1'b0;
      o_mem_wb_bubble = 1'b1;
    end

    if (w_apply) begin
      if (i_ex_redirect) begin
        o_pc_load     = 1'b1;
        o_pc_next     = i_ex_redirect_pc;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        w_state_d     = RedirState;
        w_flush_cnt_d = FlushInit;
      end else if (i_ex_stall) begin
        o_if_id_en      = 1'b0;
        o_id_ex_en      = 1'b0;
        o_ex_mem_bubble = 1'b1;
        w_stall_applied = 1'b1;
      end
    end

    if (r_state == StFlush) begin
      o_if_id_flush = 1'b1;
    end

    // Reset holds the pipeline empty regardless of state.
    if (!i_rst_n) begin
      o_if_id_en      = 1'b0;
      o_id_ex_en      = 1'b0;
      o_ex_mem_en     = 1'b0;
      o_mem_wb_en     = 1'b0;
      o_ex_mem_bubble = 1'b0;
      o_mem_wb_bubble = 1'b0;
      o_if_id_flush   = 1'b1;
      o_id_ex_flush   = 1'b1;
      o_pc_load       = 1'b0;
      o_pc_next       = '0;
      w_stall_applied = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= StRun;
      r_flush_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_flush_cnt   <= w_flush_cnt_d;
      r_wait_cnt    <= w_wait_cnt_d;
      r_mem_timeout <= w_mem_timeout_d;
    end
  end

  assign o_mem_timeout = r_mem_timeout;
  assign o_ctrl_state  = r_state;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] r_stall_cycles, r_flush_events, r_mem_wait_cycles;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cycles    <= '0;
      r_flush_events    <= '0;
      r_mem_wait_cycles <= '0;
    end else begin
      if (w_stall_applied && r_stall_cycles != CntMax) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (o_pc_load && r_flush_events != CntMax) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
      if (r_state == StMemWait && r_mem_wait_cycles != CntMax) begin
        r_mem_wait_cycles <= r_mem_wait_cycles + CNT_W'(1);
      end
    end
  end

  assign o_stall_cycles    = r_stall_cycles;
  assign o_flush_events    = r_flush_events;
  assign o_mem_wait_cycles = r_mem_wait_cycles;
`else
  logic w_unused_perf;
  assign w_unused_perf     = w_stall_applied;
  assign o_stall_cycles    = '0;
  assign o_flush_events    = '0;
  assign o_mem_wait_cycles = '0;
`endif

endmodule
